// File: rtl/wb_bus_pkg.sv
// Shared definitions for the Wishbone <-> copperv ready/valid bridge.
// Holds the responder FSM state encoding, the "OK" write-response code
// and the default bus widths so the initiator-side adapter can reuse them.
package wb_bus_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_STRB_W = WB_DATA_W / 8;
  localparam int WB_RESP_W = 1;

  // Write-response code meaning "OK"; any other value terminates with wb_err.
  localparam int BUS_RESP_OK = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_TERM    = 3'd5
  } wb_bus_state_e;

endpackage

// File: rtl/wb_bus_responder.sv
// Wishbone classic responder that turns each Wishbone read or write into one
// transaction on the copperv ready/valid bus.
//
// Ports:
//   clock, reset            clock and synchronous active-high reset
//   wb_cyc/stb/we/adr/datwr/sel   Wishbone request from the initiator
//   wb_datrd                registered read data (holds the last read value)
//   wb_ack / wb_err         one-cycle termination pulses
//   bus_r_addr_*            read address channel (valid/ready/addr)
//   bus_r_data_*            read data channel (valid/ready/data)
//   bus_w_data_addr_*       write request channel (valid/ready + addr/data/strobe)
//   bus_w_resp_*            write response channel (valid/ready/resp)
//
// Every output is either a register or a decode of registered state, so no
// input reaches an output combinationally.
module wb_bus_responder
  import wb_bus_pkg::*;
#(
  parameter int addr_width   = WB_ADDR_W,
  parameter int data_width   = WB_DATA_W,
  parameter int strobe_width = data_width / 8,
  parameter int resp_width   = WB_RESP_W
) (
  input  logic                    clock,
  input  logic                    reset,
  // Wishbone target side
  input  logic                    wb_cyc,
  input  logic                    wb_stb,
  input  logic                    wb_we,
  input  logic [addr_width-1:0]   wb_adr,
  input  logic [data_width-1:0]   wb_datwr,
  input  logic [strobe_width-1:0] wb_sel,
  output logic [data_width-1:0]   wb_datrd,
  output logic                    wb_ack,
  output logic                    wb_err,
  // copperv bus side: read
  output logic                    bus_r_addr_valid,
  input  logic                    bus_r_addr_ready,
  output logic [addr_width-1:0]   bus_r_addr,
  input  logic                    bus_r_data_valid,
  output logic                    bus_r_data_ready,
  input  logic [data_width-1:0]   bus_r_data,
  // copperv bus side: write
  output logic                    bus_w_data_addr_valid,
  input  logic                    bus_w_data_addr_ready,
  output logic [addr_width-1:0]   bus_w_addr,
  output logic [data_width-1:0]   bus_w_data,
  output logic [strobe_width-1:0] bus_w_strobe,
  input  logic                    bus_w_resp_valid,
  output logic                    bus_w_resp_ready,
  input  logic [resp_width-1:0]   bus_w_resp
);

  localparam logic [resp_width-1:0] RESP_OK = resp_width'(BUS_RESP_OK);

  wb_bus_state_e           state_q, state_d;
  logic [addr_width-1:0]   addr_q, addr_d;
  logic [data_width-1:0]   wdata_q, wdata_d;
  logic [strobe_width-1:0] sel_q, sel_d;
  logic [data_width-1:0]   rdata_q, rdata_d;
  logic                    abort_q, abort_d;
  logic                    err_q, err_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    abort_d = abort_q;
    err_d   = err_q;

    // Once a bus valid is raised it must not be retracted, so a dropped
    // wb_cyc only marks the transaction aborted; the bus side still finishes.
    if ((state_q != ST_IDLE) && (state_q != ST_TERM) && !wb_cyc) begin
      abort_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        err_d   = 1'b0;
        if (wb_cyc && wb_stb) begin
          addr_d  = wb_adr;
          wdata_d = wb_datwr;
          sel_d   = wb_sel;
          state_d = wb_we ? ST_WR_REQ : ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: if (bus_r_addr_ready) state_d = ST_RD_DATA;
      ST_RD_DATA: begin
        if (bus_r_data_valid) begin
          rdata_d = bus_r_data;
          state_d = ST_TERM;
        end
      end
      ST_WR_REQ: if (bus_w_data_addr_ready) state_d = ST_WR_RESP;
      ST_WR_RESP: begin
        if (bus_w_resp_valid) begin
          err_d   = (bus_w_resp != RESP_OK);
          state_d = ST_TERM;
        end
      end
      // TERM always returns to IDLE, so a strobe still held here is not
      // taken as a new request.
      ST_TERM: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus_r_addr_valid      = (state_q == ST_RD_ADDR);
  assign bus_r_data_ready      = (state_q == ST_RD_DATA);
  assign bus_w_data_addr_valid = (state_q == ST_WR_REQ);
  assign bus_w_resp_ready      = (state_q == ST_WR_RESP);

  assign wb_ack = (state_q == ST_TERM) && !abort_q && !err_q;
  assign wb_err = (state_q == ST_TERM) && !abort_q &&  err_q;

  assign wb_datrd     = rdata_q;
  assign bus_r_addr   = addr_q;
  assign bus_w_addr   = addr_q;
  assign bus_w_data   = wdata_q;
  assign bus_w_strobe = sel_q;

endmodule

// File: tb/tb_wb_bus_responder.sv
// Bench for wb_bus_responder: table of Wishbone transactions with a scripted
// bus slave (configurable wait cycles), expected terminations queued at
// strobe time and compared at the termination cycle, plus hand-written
// stray-input and mid-transaction reset sequences.
module tb_wb_bus_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_datwr, wb_datrd;
  logic [3:0]  wb_sel;
  logic        wb_ack, wb_err;
  logic        bus_r_addr_valid, bus_r_addr_ready;
  logic [31:0] bus_r_addr;
  logic        bus_r_data_valid, bus_r_data_ready;
  logic [31:0] bus_r_data;
  logic        bus_w_data_addr_valid, bus_w_data_addr_ready;
  logic [31:0] bus_w_addr, bus_w_data;
  logic [3:0]  bus_w_strobe;
  logic        bus_w_resp_valid, bus_w_resp_ready;
  logic [0:0]  bus_w_resp;

  wb_bus_responder dut (
    .clock(clock), .reset(reset),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_datwr(wb_datwr), .wb_sel(wb_sel), .wb_datrd(wb_datrd),
    .wb_ack(wb_ack), .wb_err(wb_err),
    .bus_r_addr_valid(bus_r_addr_valid), .bus_r_addr_ready(bus_r_addr_ready),
    .bus_r_addr(bus_r_addr),
    .bus_r_data_valid(bus_r_data_valid), .bus_r_data_ready(bus_r_data_ready),
    .bus_r_data(bus_r_data),
    .bus_w_data_addr_valid(bus_w_data_addr_valid),
    .bus_w_data_addr_ready(bus_w_data_addr_ready),
    .bus_w_addr(bus_w_addr), .bus_w_data(bus_w_data), .bus_w_strobe(bus_w_strobe),
    .bus_w_resp_valid(bus_w_resp_valid), .bus_w_resp_ready(bus_w_resp_ready),
    .bus_w_resp(bus_w_resp)
  );

  always #5 clock = ~clock;

  int cnt = 0;
  always @(posedge clock) cnt <= cnt + 1;

  // kind: 0 = no termination (aborted), 1 = wb_ack, 2 = wb_err
  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          ad;        // wait cycles before address/request ready
    int          dd;        // wait cycles before data/response valid
    logic [31:0] rdata;
    logic        resp;
    int          abort_it;  // loop iteration at which wb_cyc drops, -1 = never
    bit          keep;      // hold strobe through TERM and one more cycle
    int          kind;
    logic [31:0] datrd;
    int          lat;       // strobe edge to termination cycle
  } vec_t;

  typedef struct {
    int          kind;
    logic [31:0] datrd;
    int          due;
  } exp_t;

  vec_t vecs[10];
  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic vec_t mk(bit we, logic [31:0] adr, logic [31:0] dat,
                              logic [3:0] sel, int ad, int dd, logic [31:0] rdata,
                              logic resp, int abort_it, bit keep, int kind,
                              logic [31:0] datrd, int lat);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.ad = ad; v.dd = dd;
    v.rdata = rdata; v.resp = resp; v.abort_it = abort_it; v.keep = keep;
    v.kind = kind; v.datrd = datrd; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cnt);
    end
  endtask

  task automatic idle_check(input string name);
    check(name, {26'd0, bus_r_addr_valid, bus_r_data_ready, bus_w_data_addr_valid,
                 bus_w_resp_ready, wb_ack, wb_err}, 32'd0);
  endtask

  task automatic payload_check(input vec_t v);
    if (v.we) begin
      check("w_addr_stable", bus_w_addr, v.adr);
      check("w_data_stable", bus_w_data, v.dat);
      check("w_strobe_stable", {28'd0, bus_w_strobe}, {28'd0, v.sel});
    end else begin
      check("r_addr_stable", bus_r_addr, v.adr);
    end
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic run_txn(input vec_t v);
    int   w;
    int   phase;
    bit   done;
    exp_t e;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = v.we;
    wb_adr = v.adr; wb_datwr = v.dat; wb_sel = v.sel;
    e.kind = v.kind; e.datrd = v.datrd; e.due = cnt + v.lat;
    sbq.push_back(e);
    w = 0; phase = 0; done = 1'b0;
    for (int it = 0; it < 40 && !done; it++) begin
      @(negedge clock);
      bus_r_addr_ready = 1'b0; bus_w_data_addr_ready = 1'b0;
      bus_r_data_valid = 1'b0; bus_w_resp_valid = 1'b0;
      if (it == v.abort_it) begin wb_cyc = 1'b0; wb_stb = 1'b0; end
      case (phase)
        0: begin
          check("req_valid_held", {31'd0, v.we ? bus_w_data_addr_valid : bus_r_addr_valid}, 32'd1);
          check("no_early_term", {30'd0, wb_ack, wb_err}, 32'd0);
          payload_check(v);
          if (w == v.ad) begin
            if (v.we) bus_w_data_addr_ready = 1'b1; else bus_r_addr_ready = 1'b1;
            phase = 1; w = 0;
          end else w++;
        end
        1: begin
          check("resp_ready", {31'd0, v.we ? bus_w_resp_ready : bus_r_data_ready}, 32'd1);
          check("no_early_term", {30'd0, wb_ack, wb_err}, 32'd0);
          payload_check(v);
          if (w == v.dd) begin
            if (v.we) begin bus_w_resp_valid = 1'b1; bus_w_resp = v.resp; end
            else begin bus_r_data_valid = 1'b1; bus_r_data = v.rdata; end
            phase = 2;
          end else w++;
        end
        default: begin
          if (sbq.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL scoreboard_empty: got termination cycle, required a queued entry");
          end else begin
            e = sbq.pop_front();
            check("wb_ack", {31'd0, wb_ack}, {31'd0, e.kind == 1});
            check("wb_err", {31'd0, wb_err}, {31'd0, e.kind == 2});
            check("wb_datrd", wb_datrd, e.datrd);
            check("term_cycle", cnt, e.due);
          end
          if (!v.keep) begin wb_cyc = 1'b0; wb_stb = 1'b0; end
          done = 1'b1;
        end
      endcase
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL txn_timeout: got no termination within 40 cycles, required one");
      wb_cyc = 1'b0; wb_stb = 1'b0;
    end
    if (v.keep) begin
      @(negedge clock);
      idle_check("held_stb_not_reaccepted");
      wb_cyc = 1'b0; wb_stb = 1'b0;
    end
    @(negedge clock);
    idle_check("idle_after_txn");
  endtask

  initial begin
    reset = 1'b1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_adr = '0; wb_datwr = '0; wb_sel = '0;
    bus_r_addr_ready = 1'b0; bus_r_data_valid = 1'b0; bus_r_data = '0;
    bus_w_data_addr_ready = 1'b0; bus_w_resp_valid = 1'b0; bus_w_resp = '0;

    //            we  adr         dat           sel   ad dd rdata         rsp ab keep kind datrd        lat
    vecs[0] = mk(0, 32'h100, 32'h0,        4'hF, 0, 0, 32'hDEADBEEF, 1, -1, 0, 1, 32'hDEADBEEF, 3);
    vecs[1] = mk(1, 32'h020, 32'h12345678, 4'h3, 2, 3, 32'h0,        1, -1, 0, 1, 32'hDEADBEEF, 8);
    vecs[2] = mk(1, 32'h024, 32'hCAFEF00D, 4'hF, 0, 0, 32'h0,        0, -1, 0, 2, 32'hDEADBEEF, 3);
    vecs[3] = mk(0, 32'h200, 32'h0,        4'hF, 1, 2, 32'h0BADF00D, 1, -1, 0, 1, 32'h0BADF00D, 6);
    vecs[4] = mk(0, 32'h300, 32'h0,        4'hF, 0, 1, 32'h55AA55AA, 1,  1, 0, 0, 32'h55AA55AA, 4);
    vecs[5] = mk(1, 32'h040, 32'h00000009, 4'hC, 0, 0, 32'h0,        1, -1, 1, 1, 32'h55AA55AA, 3);
    vecs[6] = mk(0, 32'h044, 32'h0,        4'hF, 0, 0, 32'hA5A5A5A5, 1, -1, 1, 1, 32'hA5A5A5A5, 3);
    vecs[7] = mk(1, 32'h048, 32'hFFFF0000, 4'h1, 1, 1, 32'h0,        0, -1, 0, 2, 32'hA5A5A5A5, 5);
    vecs[8] = mk(0, 32'h104, 32'h0,        4'hF, 0, 0, 32'h13579BDF, 1, -1, 0, 1, 32'h13579BDF, 3);
    vecs[9] = mk(0, 32'h108, 32'h0,        4'hF, 2, 0, 32'h2468ACE0, 1, -1, 0, 1, 32'h2468ACE0, 5);

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    idle_check("reset_handshakes");
    check("reset_datrd", wb_datrd, 32'd0);
    check("reset_r_addr", bus_r_addr, 32'd0);
    check("reset_w_payload", bus_w_addr | bus_w_data | {28'd0, bus_w_strobe}, 32'd0);

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Stray response-side valids while idle must be ignored.
    bus_r_data_valid = 1'b1; bus_r_data = 32'hFFFFFFFF;
    bus_w_resp_valid = 1'b1; bus_w_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      idle_check("stray_no_ready");
      check("stray_datrd", wb_datrd, 32'hA5A5A5A5);
    end
    bus_r_data_valid = 1'b0; bus_w_resp_valid = 1'b0;
    run_txn(vecs[8]);

    // Reset while the write request is pending.
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
    wb_adr = 32'h80; wb_datwr = 32'h77778888; wb_sel = 4'h6;
    @(negedge clock);
    check("pre_reset_wr_req", {31'd0, bus_w_data_addr_valid}, 32'd1);
    reset = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clock);
    idle_check("midreset_handshakes");
    check("midreset_datrd", wb_datrd, 32'd0);
    check("midreset_payload", bus_w_addr | bus_w_data | {28'd0, bus_w_strobe} | bus_r_addr, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    idle_check("post_reset_idle");
    run_txn(vecs[9]);

    if (sbq.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries, required 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_bus_responder.md
# wb_bus_responder

Wishbone classic single-cycle responder that converts each Wishbone read or write into one transaction on the copperv ready/valid bus. The Wishbone side is the target of an initiator such as the CPU-side bus-to-Wishbone adapter. The bus side drives a copperv memory or peripheral slave. Together the two blocks form a back-to-back bridge, and this block lets existing copperv bus slaves sit behind a Wishbone interconnect.

## Interface
- addr_width, 32, address width on both sides
- data_width, 32, data width on both sides
- strobe_width, data_width/8, byte-select / write-strobe width
- resp_width, 1, write-response width; value 1 = OK, any other value = error
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- wb_cyc  in  1  cycle valid
- wb_stb  in  1  strobe
- wb_we  in  1  write enable
- wb_adr  in  addr_width  address
- wb_datwr  in  data_width  write data
- wb_sel  in  strobe_width  byte selects
- wb_datrd  out  data_width  read data, registered
- wb_ack  out  1  normal termination, one-cycle pulse
- wb_err  out  1  error termination, one-cycle pulse
- bus_r_addr_valid / bus_r_addr_ready  out / in  1  read address handshake
- bus_r_addr  out  addr_width  read address
- bus_r_data_valid / bus_r_data_ready  in / out  1  read data handshake
- bus_r_data  in  data_width  read data
- bus_w_data_addr_valid / bus_w_data_addr_ready  out / in  1  write request handshake
- bus_w_addr, bus_w_data, bus_w_strobe  out  addr_width / data_width / strobe_width  write request payload
- bus_w_resp_valid / bus_w_resp_ready  in / out  1  write response handshake
- bus_w_resp  in  resp_width  write response code

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, TERM.
- IDLE:
  - When wb_cyc && wb_stb, latch wb_adr, wb_datwr and wb_sel into the bus payload registers.
  - Clear the abort and err flags.
  - Go to WR_REQ if wb_we, otherwise RD_ADDR.
- RD_ADDR:
  - bus_r_addr_valid = 1.
  - On bus_r_addr_ready, go to RD_DATA.
- RD_DATA:
  - bus_r_data_ready = 1.
  - On bus_r_data_valid, register bus_r_data into wb_datrd and go to TERM.
- WR_REQ:
  - bus_w_data_addr_valid = 1.
  - On bus_w_data_addr_ready, go to WR_RESP.
- WR_RESP:
  - bus_w_resp_ready = 1.
  - On bus_w_resp_valid, set err = (bus_w_resp != 1) and go to TERM.
- TERM:
  - If abort is clear, assert wb_ack (err=0) or wb_err (err=1) for exactly this cycle.
  - Go to IDLE.
- Abort: if wb_cyc is low in any of RD_ADDR, RD_DATA, WR_REQ or WR_RESP, set the abort flag.
  - The bus transaction still runs to completion, because a valid signal is never retracted once asserted.
  - TERM then suppresses both wb_ack and wb_err.
- Bus payload outputs stay stable from latch until the next IDLE accept.
- wb_datrd holds its last read value. Writes do not change it.
- Handshake inputs arriving in any state that does not own them are ignored: stray bus_r_data_valid or bus_w_resp_valid are not consumed because the matching ready is low.
- Reset values: every valid, ready, wb_ack and wb_err = 0; wb_datrd, bus_r_addr, bus_w_addr, bus_w_data and bus_w_strobe = 0; state = IDLE; abort and err flags = 0.
- Reset mid-transaction: return to IDLE with no termination pulse. The bus slave is also under reset.

## Timing
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Read, zero-wait slave:
  - cyc&stb sampled at edge T.
  - bus_r_addr_valid high in T+1. If ready is high in T+1, bus_r_data_ready is high in T+2.
  - If data_valid is high in T+2, wb_ack and wb_datrd are valid in T+3.
  - Minimum latency from strobe edge to ack is 3 cycles. Each bus wait cycle adds 1.
- Write, zero-wait slave: same schedule. wb_ack (or wb_err) is in T+3.
- A valid stays high until the cycle in which its ready is seen. The handshake completes on the edge where both are high.
- Back-to-back: IDLE accepts a new request in the cycle after TERM, so throughput is 1 transaction per 4 cycles minimum. A strobe still high during TERM is not re-accepted.

## Structure
- Shared package wb_bus_pkg holds:
  - the state enum encoding,
  - the constant BUS_RESP_OK = 1,
  - the default width constants, so the initiator-side adapter can share them.
- Single module with no sub-module. The FSM and payload registers are one unit, and splitting them adds only port wiring.

## Test plan
- Read, zero-wait: wb_adr=0x100, bus slave returns 0xDEADBEEF -> bus_r_addr=0x100 in T+1, wb_datrd=0xDEADBEEF with a one-cycle wb_ack in T+3.
- Write with stalls: wb_adr=0x20, wb_datwr=0x12345678, wb_sel=0b0011; addr_ready delayed 2 cycles, resp delayed 3 cycles -> payload stable throughout, valid held, wb_ack in T+8.
- Write error: bus_w_resp=0 -> wb_err pulses once, wb_ack stays 0.
- Abort: drop wb_cyc while in RD_DATA -> the bus read still completes, no wb_ack or wb_err, back in IDLE the next cycle.
- Stray inputs: bus_r_data_valid and bus_w_resp_valid pulsed while in IDLE -> no ready asserted, no state change, no termination.
- Reset during WR_REQ -> all outputs 0 the next cycle, and a following read completes normally.
